// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM state encoding,
// the default datapath width and a small access-decode helper.
package mem_stage_pkg;

    // Default datapath width of the stage.
    localparam int XLEN_DEFAULT = 64;

    // Memory-access sequencer states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    // True when the EX/MEM control word asks for a data-memory access.
    function automatic logic is_mem_op(input logic mem_read, input logic mem_write);
        return mem_read | mem_write;
    endfunction

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register. A bubble clears every field so the write-back
// stage sees a harmless no-op while the memory stage is still waiting.
module mem_wb_register
    import mem_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            bubble,
    input  logic [XLEN-1:0] read_data,
    input  logic [XLEN-1:0] alu_result,
    input  logic [4:0]      rd,
    input  logic            memToReg,
    input  logic            reg_write,
    output logic [XLEN-1:0] read_data_reg,
    output logic [XLEN-1:0] alu_result_reg,
    output logic [4:0]      rd_reg,
    output logic            memToReg_reg,
    output logic            reg_write_reg
);

    // Capture the stage result, or load a bubble; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            read_data_reg  <= {XLEN{1'b0}};
            alu_result_reg <= {XLEN{1'b0}};
            rd_reg         <= 5'd0;
            memToReg_reg   <= 1'b0;
            reg_write_reg  <= 1'b0;
        end else begin
            read_data_reg  <= read_data;
            alu_result_reg <= alu_result;
            rd_reg         <= rd;
            memToReg_reg   <= memToReg;
            reg_write_reg  <= reg_write;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: resolves branches, sequences data-memory accesses
// through a two-state IDLE/BUSY handshake and feeds the MEM/WB register.
// Every memory op spends one IDLE cycle (stall raised) before issuing its
// request in BUSY, so back-to-back accesses never overlap.
// Optional feature: define MEM_TIMEOUT_EN to abort a BUSY access after
// TIMEOUT_CYCLES unacknowledged cycles and raise the sticky mem_error flag.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_plus_imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] rd2,
    input  logic [4:0]      rd,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            memToReg,
    input  logic            branch,
    input  logic            reg_write,
    input  logic            zero,
    output logic            pc_src,
    output logic [XLEN-1:0] branch_target,
    output logic            flush,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic [XLEN-1:0] read_data_reg,
    output logic [XLEN-1:0] alu_result_reg,
    output logic [4:0]      rd_reg,
    output logic            memToReg_reg,
    output logic            reg_write_reg,
    output logic            mem_error
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_stage: TIMEOUT_CYCLES must be at least 1");
    end

    mem_state_e      state_r;
    mem_state_e      next_state_s;
    logic            busy_s;
    logic            stall_s;
    logic            bubble_s;
    logic            timeout_hit_s;
    logic [XLEN-1:0] wb_read_data_s;

    assign busy_s = (state_r == ST_BUSY);

    // Branch resolution is purely combinational from the EX/MEM fields.
    assign pc_src        = branch & zero;
    assign flush         = branch & zero;
    assign branch_target = pc_plus_imm;

    // Request is only visible in BUSY and is masked while reset is held.
    assign dmem_req   = busy_s & ~reset;
    assign dmem_we    = busy_s & ~reset & mem_write;
    assign dmem_addr  = busy_s ? alu_result : {XLEN{1'b0}};
    assign dmem_wdata = busy_s ? rd2 : {XLEN{1'b0}};
    assign stall      = stall_s;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_r;
    logic             mem_error_r;

    // The last allowed unacked BUSY cycle aborts the access.
    assign timeout_hit_s = busy_s && !dmem_ack &&
                           (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count unacked BUSY cycles; latch the error flag on abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_r   <= {CNT_W{1'b0}};
            mem_error_r <= 1'b0;
        end else begin
            if (busy_s && !dmem_ack && !timeout_hit_s) begin
                tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
            end else begin
                tmo_cnt_r <= {CNT_W{1'b0}};
            end
            if (timeout_hit_s) begin
                mem_error_r <= 1'b1;
            end else begin
                mem_error_r <= mem_error_r;
            end
        end
    end

    assign mem_error = mem_error_r;
`else
    assign timeout_hit_s = 1'b0;
    assign mem_error     = 1'b0;
`endif

    // Next-state, stall and MEM/WB selection for the access sequencer.
    always_comb begin
        next_state_s   = state_r;
        stall_s        = 1'b0;
        bubble_s       = 1'b0;
        wb_read_data_s = {XLEN{1'b0}};
        case (state_r)
            ST_IDLE: begin
                // dmem_ack is deliberately ignored here.
                if (is_mem_op(mem_read, mem_write)) begin
                    stall_s      = 1'b1;
                    bubble_s     = 1'b1;
                    next_state_s = ST_BUSY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (dmem_ack) begin
                    next_state_s = ST_IDLE;
                    if (mem_read) begin
                        wb_read_data_s = dmem_rdata;
                    end else begin
                        wb_read_data_s = {XLEN{1'b0}};
                    end
                end else if (timeout_hit_s) begin
                    bubble_s     = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    stall_s      = 1'b1;
                    bubble_s     = 1'b1;
                    next_state_s = ST_BUSY;
                end
            end
            default: begin
                bubble_s     = 1'b1;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register; reset wins over any pending ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    mem_wb_register #(
        .XLEN (XLEN)
    ) u_mem_wb (
        .clk            (clk),
        .reset          (reset),
        .bubble         (bubble_s),
        .read_data      (wb_read_data_s),
        .alu_result     (alu_result),
        .rd             (rd),
        .memToReg       (memToReg),
        .reg_write      (reg_write),
        .read_data_reg  (read_data_reg),
        .alu_result_reg (alu_result_reg),
        .rd_reg         (rd_reg),
        .memToReg_reg   (memToReg_reg),
        .reg_write_reg  (reg_write_reg)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a table of single-cycle (non-memory)
// vectors followed by hand-written load/store/reset/timeout sequences.
module tb_mem_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] pc_plus_imm, alu_result, rd2;
    logic [4:0]      rd;
    logic            mem_read, mem_write, memToReg, branch, reg_write, zero;
    logic            pc_src, flush, stall;
    logic [XLEN-1:0] branch_target;
    logic            dmem_req, dmem_we;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic            dmem_ack;
    logic [XLEN-1:0] read_data_reg, alu_result_reg;
    logic [4:0]      rd_reg;
    logic            memToReg_reg, reg_write_reg, mem_error;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(XLEN), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .pc_plus_imm(pc_plus_imm), .alu_result(alu_result), .rd2(rd2),
        .rd(rd), .mem_read(mem_read), .mem_write(mem_write),
        .memToReg(memToReg), .branch(branch), .reg_write(reg_write), .zero(zero),
        .pc_src(pc_src), .branch_target(branch_target), .flush(flush),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .read_data_reg(read_data_reg), .alu_result_reg(alu_result_reg),
        .rd_reg(rd_reg), .memToReg_reg(memToReg_reg),
        .reg_write_reg(reg_write_reg), .mem_error(mem_error)
    );

    typedef struct {
        logic [63:0] ppi;
        logic [63:0] alu;
        logic [4:0]  rd;
        logic        branch;
        logic        zero;
        logic        rw;
        logic        mtr;
        logic        exp_pc_src;
        logic [63:0] exp_alu_reg;
        logic [4:0]  exp_rd_reg;
        logic        exp_rw_reg;
        logic        exp_mtr_reg;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        pc_plus_imm = 64'h0; alu_result = 64'h0; rd2 = 64'h0; rd = 5'd0;
        mem_read = 1'b0; mem_write = 1'b0; memToReg = 1'b0; branch = 1'b0;
        reg_write = 1'b0; zero = 1'b0; dmem_rdata = 64'h0; dmem_ack = 1'b0;
    endtask

    initial begin
        int stall_cycles;

        vecs[0] = '{64'h0,  64'h10, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h10, 5'd5,  1'b1, 1'b0};
        vecs[1] = '{64'h40, 64'h0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0,  5'd0,  1'b0, 1'b0};
        vecs[2] = '{64'h40, 64'h0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  5'd0,  1'b0, 1'b0};
        vecs[3] = '{64'h80, 64'h3,  5'd2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h3,  5'd2,  1'b1, 1'b0};
        vecs[4] = '{64'h0,  64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 1'b1, 1'b1};
        vecs[5] = '{64'h0,  64'h0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  5'd0,  1'b0, 1'b0};

        // Reset state
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dmem_req", dmem_req, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_reg_write_reg", reg_write_reg, 1'b0);
        chk("rst_read_data_reg", read_data_reg, 64'h0);
        chk("rst_mem_error", mem_error, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven non-memory vectors
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pc_plus_imm = vecs[i].ppi; alu_result = vecs[i].alu; rd = vecs[i].rd;
            branch = vecs[i].branch; zero = vecs[i].zero;
            reg_write = vecs[i].rw; memToReg = vecs[i].mtr;
            dmem_rdata = 64'hBAD0_BAD0; dmem_ack = 1'b1;
            #1;
            chk("vec_pc_src", pc_src, vecs[i].exp_pc_src);
            chk("vec_flush", flush, vecs[i].exp_pc_src);
            chk("vec_branch_target", branch_target, vecs[i].ppi);
            chk("vec_stall", stall, 1'b0);
            chk("vec_dmem_req", dmem_req, 1'b0);
            @(posedge clk);
            #1;
            chk("vec_alu_result_reg", alu_result_reg, vecs[i].exp_alu_reg);
            chk("vec_rd_reg", rd_reg, vecs[i].exp_rd_reg);
            chk("vec_reg_write_reg", reg_write_reg, vecs[i].exp_rw_reg);
            chk("vec_memToReg_reg", memToReg_reg, vecs[i].exp_mtr_reg);
            chk("vec_read_data_reg", read_data_reg, 64'h0);
        end

        // Load at 0x100, ack after 3 unacked BUSY cycles; ack in IDLE ignored
        @(negedge clk);
        idle_inputs();
        mem_read = 1'b1; alu_result = 64'h100; rd = 5'd7; reg_write = 1'b1;
        memToReg = 1'b1; dmem_rdata = 64'hDEAD; dmem_ack = 1'b1;
        stall_cycles = 0;
        #1;
        chk("ld_idle_req", dmem_req, 1'b0);
        if (stall) stall_cycles++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            dmem_ack = 1'b0;
            #1;
            chk("ld_busy_req", dmem_req, 1'b1);
            chk("ld_busy_addr", dmem_addr, 64'h100);
            chk("ld_busy_we", dmem_we, 1'b0);
            chk("ld_bubble_rw", reg_write_reg, 1'b0);
            if (stall) stall_cycles++;
        end
        chk("ld_stall_cycles", stall_cycles, 4);
        @(negedge clk);
        dmem_ack = 1'b1;
        #1;
        chk("ld_ack_stall", stall, 1'b0);
        chk("ld_ack_addr", dmem_addr, 64'h100);
        @(posedge clk);
        #1;
        chk("ld_read_data_reg", read_data_reg, 64'hDEAD);
        chk("ld_memToReg_reg", memToReg_reg, 1'b1);
        chk("ld_reg_write_reg", reg_write_reg, 1'b1);
        chk("ld_rd_reg", rd_reg, 5'd7);
        chk("ld_alu_result_reg", alu_result_reg, 64'h100);

        // Back-to-back load: must go through IDLE again, no overlap
        @(negedge clk);
        alu_result = 64'h108; rd = 5'd8; dmem_rdata = 64'h1234; dmem_ack = 1'b0;
        #1;
        chk("b2b_idle_req", dmem_req, 1'b0);
        chk("b2b_idle_stall", stall, 1'b1);
        @(negedge clk);
        dmem_ack = 1'b1;
        #1;
        chk("b2b_busy_req", dmem_req, 1'b1);
        chk("b2b_busy_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        chk("b2b_read_data_reg", read_data_reg, 64'h1234);

        // Store 0x55 to 0x200, acked on first BUSY cycle
        @(negedge clk);
        idle_inputs();
        mem_write = 1'b1; alu_result = 64'h200; rd2 = 64'h55;
        dmem_rdata = 64'hBEEF;
        #1;
        chk("st_idle_stall", stall, 1'b1);
        @(negedge clk);
        dmem_ack = 1'b1;
        #1;
        chk("st_req", dmem_req, 1'b1);
        chk("st_we", dmem_we, 1'b1);
        chk("st_wdata", dmem_wdata, 64'h55);
        chk("st_addr", dmem_addr, 64'h200);
        chk("st_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        chk("st_reg_write_reg", reg_write_reg, 1'b0);
        chk("st_read_data_reg", read_data_reg, 64'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("st_after_req", dmem_req, 1'b0);

        // Reset during BUSY, late ack ignored
        @(negedge clk);
        mem_read = 1'b1; alu_result = 64'h300; rd = 5'd9; reg_write = 1'b1;
        memToReg = 1'b1; dmem_rdata = 64'hCAFE;
        @(negedge clk);
        #1;
        chk("rb_busy_req", dmem_req, 1'b1);
        reset = 1'b1;
        #1;
        chk("rb_req_in_reset", dmem_req, 1'b0);
        @(posedge clk);
        #1;
        chk("rb_rw_reg", reg_write_reg, 1'b0);
        chk("rb_read_data_reg", read_data_reg, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        dmem_ack = 1'b1; dmem_rdata = 64'hCAFE;
        #1;
        chk("rb_late_ack_req", dmem_req, 1'b0);
        chk("rb_late_ack_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        chk("rb_late_read_data", read_data_reg, 64'h0);
        chk("rb_late_mtr", memToReg_reg, 1'b0);

`ifdef MEM_TIMEOUT_EN
        // No ack: 16 BUSY cycles then abort with mem_error
        @(negedge clk);
        idle_inputs();
        mem_read = 1'b1; alu_result = 64'h400; rd = 5'd3; reg_write = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            #1;
            chk("to_req", dmem_req, 1'b1);
            chk("to_stall", stall, (c < 15) ? 1'b1 : 1'b0);
            chk("to_err_pending", mem_error, 1'b0);
            @(negedge clk);
        end
        mem_read = 1'b0; reg_write = 1'b0;
        #1;
        chk("to_mem_error", mem_error, 1'b1);
        chk("to_rw_reg", reg_write_reg, 1'b0);
        chk("to_req_after", dmem_req, 1'b0);
`else
        // Without timeout the access waits indefinitely
        @(negedge clk);
        idle_inputs();
        mem_read = 1'b1; alu_result = 64'h400;
        repeat (21) @(negedge clk);
        #1;
        chk("nt_still_stall", stall, 1'b1);
        chk("nt_still_req", dmem_req, 1'b1);
        chk("nt_mem_error", mem_error, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64: datapath width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: BUSY cycles without ack before abort (used only with MEM_TIMEOUT_EN).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports pc_plus_imm, alu_result, rd2  in  XLEN each  EX/MEM register outputs: branch target, address/result, store data.
REQ-006 SHALL have ports rd  in  5;  mem_read, mem_write, memToReg, branch, reg_write, zero  in  1 each  EX/MEM control.
REQ-007 SHALL have ports pc_src  out  1  take branch;  branch_target  out  XLEN  equals pc_plus_imm;  flush  out  1  squash younger stages.
REQ-008 SHALL have port stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM.
REQ-009 SHALL have ports dmem_req, dmem_we  out  1;  dmem_addr, dmem_wdata  out  XLEN;  dmem_rdata  in  XLEN;  dmem_ack  in  1.
REQ-010 SHALL have ports read_data_reg, alu_result_reg  out  XLEN;  rd_reg  out  5;  memToReg_reg, reg_write_reg  out  1  MEM/WB register.
REQ-011 SHALL have port mem_error  out  1  sticky timeout flag.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY.
REQ-013 IDLE with mem_read|mem_write: stall=1 combinationally, next state BUSY; dmem_ack ignored in IDLE.
REQ-014 BUSY: dmem_req=1, dmem_we=mem_write, dmem_addr=alu_result, dmem_wdata=rd2, all held stable until ack.
REQ-015 BUSY without dmem_ack: stall=1; MEM/WB loads bubble (reg_write_reg=0, memToReg_reg=0).
REQ-016 BUSY with dmem_ack: stall=0 same cycle; next edge MEM/WB captures dmem_rdata (loads; zero for stores) plus alu_result, rd, memToReg, reg_write; state IDLE.
REQ-017 Memory op latency: 2 cycles minimum (IDLE + acked BUSY), +1 per ack wait cycle.
REQ-018 Non-memory op: stall=0, dmem_req=0, MEM/WB captures next edge (latency 1), read_data_reg=0.
REQ-019 pc_src = branch & zero and flush = pc_src, both combinational; branch_target = pc_plus_imm.
REQ-020 Back-to-back memory ops: each SHALL take its own IDLE->BUSY sequence; no request overlap.
REQ-021 dmem_req SHALL be 0 in IDLE; never asserted while reset is high.

Reset
REQ-022 reset SHALL force state IDLE, timeout counter 0, mem_error 0, all MEM/WB outputs 0 at the next edge, taking priority over ack.
REQ-023 reset during BUSY SHALL abandon the access; a late dmem_ack after reset SHALL be ignored.

Configuration
REQ-024 With MEM_TIMEOUT_EN defined: counter increments each unacked BUSY cycle; at TIMEOUT_CYCLES: mem_error set (sticky until reset), bubble to MEM/WB, stall=0, state IDLE.
REQ-025 Without MEM_TIMEOUT_EN: no counter, BUSY waits indefinitely, mem_error tied 0.

Structure
REQ-026 Package mem_stage_pkg SHALL hold the FSM state typedef and the XLEN default constant.
REQ-027 MEM/WB capture SHALL be a sub-module mem_wb_register (clk, reset, data/control in, *_reg out).

Verification
REQ-028 ALU op alu_result=0x10, rd=5, reg_write=1 -> next cycle alu_result_reg=0x10, rd_reg=5, reg_write_reg=1, stall never high.
REQ-029 Load addr 0x100, ack after 3 BUSY cycles, rdata=0xDEAD -> stall high 4 cycles, dmem_addr=0x100 stable, then read_data_reg=0xDEAD, memToReg_reg=1.
REQ-030 Store addr 0x200, rd2=0x55, ack first BUSY cycle -> one req cycle with dmem_we=1, dmem_wdata=0x55; reg_write_reg=0.
REQ-031 branch=1, zero=1, pc_plus_imm=0x40 -> pc_src=1, flush=1, branch_target=0x40 same cycle; zero=0 -> pc_src=0.
REQ-032 reset asserted in BUSY, ack next cycle -> dmem_req=0, state IDLE, MEM/WB outputs 0, ack ignored.
REQ-033 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> mem_error=1 after 16 BUSY cycles, stall drops, reg_write_reg=0.
